// File: rtl/vram_arb.sv
// vram_arb: system-side vram arbiter between the Earthrise drawing engine and the CPU.
// Optional wait-cycle statistics are enabled with `define VRAM_ARB_STATS_EN.
module vram_arb #(
    parameter int WORD     = 32,
    parameter int ADDRW    = 14,
    parameter int ER_BURST = 4,
    parameter int RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VRAM_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      cpu_wait_cnt,
`endif
    input  logic             cpu_req,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [WORD-1:0]  cpu_wmask,
    input  logic [WORD-1:0]  cpu_din,
    output logic             cpu_ack,
    output logic [WORD-1:0]  cpu_dout,
    output logic             cpu_rvalid,
    input  logic             er_req,
    input  logic [ADDRW-1:0] er_addr,
    input  logic [WORD-1:0]  er_wmask,
    input  logic [WORD-1:0]  er_din,
    output logic             er_ack,
    output logic [ADDRW-1:0] vram_addr,
    output logic [WORD-1:0]  vram_wmask,
    output logic [WORD-1:0]  vram_din,
    input  logic [WORD-1:0]  vram_dout
);

    localparam int RUNW = $clog2(ER_BURST + 1);
    localparam logic [RUNW-1:0] RUN_MAX = RUNW'(ER_BURST);

    logic            last_er_r;
    logic [RUNW-1:0] run_r;
    logic            last_er_nxt_s;
    logic [RUNW-1:0] run_nxt_s;
    logic            grant_er_s;
    logic            grant_cpu_s;
    logic            rd_accept_s;
    logic [RD_LAT:0] rd_pipe_r;
    logic [WORD-1:0] dout_hold_r;

    // Grant decision: Earthrise wins contention until it has used its burst allowance.
    always_comb begin
        grant_er_s  = 1'b0;
        grant_cpu_s = 1'b0;
        if (rst) begin
            grant_er_s  = 1'b0;
            grant_cpu_s = 1'b0;
        end else if (er_req && cpu_req) begin
            if (!last_er_r || (run_r < RUN_MAX)) begin
                grant_er_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b1;
            end
        end else if (er_req) begin
            grant_er_s = 1'b1;
        end else if (cpu_req) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_er_s  = 1'b0;
            grant_cpu_s = 1'b0;
        end
    end

    assign er_ack      = grant_er_s;
    assign cpu_ack     = grant_cpu_s;
    assign rd_accept_s = grant_cpu_s && (cpu_wmask == {WORD{1'b0}});

    // Next arbiter state: burst counter saturates at the allowance; idle cycles end a burst.
    always_comb begin
        last_er_nxt_s = last_er_r;
        run_nxt_s     = run_r;
        if (grant_er_s) begin
            last_er_nxt_s = 1'b1;
            if (run_r == RUN_MAX) begin
                run_nxt_s = run_r;
            end else begin
                run_nxt_s = run_r + {{(RUNW-1){1'b0}}, 1'b1};
            end
        end else if (grant_cpu_s) begin
            last_er_nxt_s = 1'b0;
            run_nxt_s     = {RUNW{1'b0}};
        end else begin
            run_nxt_s = {RUNW{1'b0}};
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_er_r <= 1'b0;
            run_r     <= {RUNW{1'b0}};
        end else begin
            last_er_r <= last_er_nxt_s;
            run_r     <= run_nxt_s;
        end
    end

    // Vram command register; idle cycles drop the mask so no stale write repeats.
    always_ff @(posedge clk) begin
        if (rst) begin
            vram_addr  <= {ADDRW{1'b0}};
            vram_wmask <= {WORD{1'b0}};
            vram_din   <= {WORD{1'b0}};
        end else if (grant_er_s) begin
            vram_addr  <= er_addr;
            vram_wmask <= er_wmask;
            vram_din   <= er_din;
        end else if (grant_cpu_s) begin
            vram_addr  <= cpu_addr;
            vram_wmask <= cpu_wmask;
            vram_din   <= cpu_din;
        end else begin
            vram_wmask <= {WORD{1'b0}};
        end
    end

    // Read token pipeline; reset discards reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe_r <= {(RD_LAT+1){1'b0}};
        end else begin
            rd_pipe_r <= {rd_pipe_r[RD_LAT-1:0], rd_accept_s};
        end
    end

    assign cpu_rvalid = rd_pipe_r[RD_LAT];

    // Capture returned read data so cpu_dout holds until the next rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_hold_r <= {WORD{1'b0}};
        end else if (cpu_rvalid) begin
            dout_hold_r <= vram_dout;
        end else begin
            dout_hold_r <= dout_hold_r;
        end
    end

    // vram_dout is only valid in the rvalid cycle itself, so pass it straight through then.
    assign cpu_dout = cpu_rvalid ? vram_dout : dout_hold_r;

`ifdef VRAM_ARB_STATS_EN
    // CPU wait-cycle counter; clear beats increment, count saturates.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cpu_wait_cnt <= 16'h0000;
        end else if (cpu_req && !cpu_ack && (cpu_wait_cnt != 16'hFFFF)) begin
            cpu_wait_cnt <= cpu_wait_cnt + 16'h0001;
        end else begin
            cpu_wait_cnt <= cpu_wait_cnt;
        end
    end
`endif

endmodule

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Arbitrates the system-side vram port between two requesters: the Earthrise drawing engine (write-only) and the CPU (read/write).
- Sits in the clk_sys domain, between the requesters and vram's addr_sys/wmask_sys/din_sys/dout_sys.
- Bounded-burst priority: Earthrise streams fills, and the CPU is guaranteed service within ER_BURST+1 cycles.
- Registers the vram command and returns CPU read data with a valid strobe.

Parameters:
- WORD, 32, data and write-mask width (bits)
- ADDRW, 14, vram word address width (bits)
- ER_BURST, 4, maximum consecutive Earthrise grants while the CPU is waiting (≥1)
- RD_LAT, 1, vram read latency from registered address to vram_dout (cycles, ≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cpu_req  in  1  CPU access request
- cpu_addr  in  ADDRW  CPU word address
- cpu_wmask  in  WORD  CPU bit write mask; 0 = read
- cpu_din  in  WORD  CPU write data
- cpu_ack  out  1  CPU request accepted this cycle
- cpu_dout  out  WORD  CPU read data
- cpu_rvalid  out  1  cpu_dout valid (one cycle)
- er_req  in  1  Earthrise write request
- er_addr  in  ADDRW  Earthrise word address
- er_wmask  in  WORD  Earthrise bit write mask
- er_din  in  WORD  Earthrise write data
- er_ack  out  1  Earthrise request accepted this cycle
- vram_addr  out  ADDRW  to vram addr_sys
- vram_wmask  out  WORD  to vram wmask_sys
- vram_din  out  WORD  to vram din_sys
- vram_dout  in  WORD  from vram dout_sys

Interface (already decided):
- One clock, clk.
- rst is synchronous and active-high.

Behaviour:
- Handshake:
  - A transfer occurs when req && ack in the same cycle.
  - Requesters hold req, addr, wmask and din stable until ack.
  - cpu_ack and er_ack are combinational from the req inputs and the arbiter state.
  - cpu_ack and er_ack are never both high.
- Arbiter state:
  - last_er (1 bit): last grant went to Earthrise.
  - run: consecutive Earthrise grants, width $clog2(ER_BURST+1), saturating.
- Grant rules, evaluated each cycle:
  - Neither requesting: no grant. run <= 0; last_er unchanged.
  - Only er_req: grant Earthrise. run <= sat(run+1).
  - Only cpu_req: grant CPU. run <= 0.
  - Both, and (!last_er or run < ER_BURST): grant Earthrise. run <= sat(run+1).
  - Both, and last_er and run ≥ ER_BURST: grant CPU. run <= 0.
  - Any grant sets last_er to the grantee.
- Command register (1 cycle after accept):
  - vram_addr/vram_wmask/vram_din <= the granted requester's addr/wmask/din.
  - No grant: vram_wmask <= 0 and vram_addr holds its value, so vram never sees a spurious write.
- CPU reads (cpu_wmask == 0):
  - On accept, a read token enters a shift pipeline of depth 1+RD_LAT.
  - cpu_rvalid is high exactly 1+RD_LAT cycles after the accept cycle (2 with defaults).
  - cpu_dout <= vram_dout on that cycle and holds until the next rvalid.
  - Back-to-back reads are accepted every cycle and return in order, one per cycle.
- CPU writes: no rvalid.
- Earthrise: write-only. er_wmask == 0 is accepted and issued as a no-op.
- Reset (any cycle, including mid-operation):
  - cpu_ack, er_ack, cpu_rvalid = 0; vram_addr, vram_wmask, vram_din, cpu_dout = 0.
  - last_er = 0, so Earthrise wins the first contention.
  - run = 0; the read pipeline is flushed, and in-flight reads never produce rvalid.
  - Acks are forced low during rst even if reqs are high.
- Fairness: under continuous contention the grant sequence is ER×ER_BURST, CPU, repeating. CPU wait ≤ ER_BURST cycles.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and output cpu_wait_cnt (16).
  - cpu_wait_cnt increments each cycle with cpu_req && !cpu_ack and saturates at 16'hFFFF.
  - stats_clr or rst zeroes it; stats_clr wins over increment.
  - Value is registered and visible the cycle after the event.
- Undefined: ports and logic absent; arbitration is identical.

Test Plan:
- Reset then idle
  - Stimulus: rst 2 cycles, no reqs for 10 cycles.
  - Required: all outputs 0; vram_wmask stays 0.
- Earthrise alone
  - Stimulus: er_req held 8 cycles with addr 0..7, wmask FFFFFFFF, din A5A5A5A5.
  - Required: er_ack every cycle; vram_addr 0..7 appear one cycle later.
- CPU read
  - Stimulus: vram model with RD_LAT=1 returning addr+1000; cpu_req read at addr 100.
  - Required: cpu_ack same cycle; cpu_rvalid exactly 2 cycles later with cpu_dout 1100; no extra rvalid.
- Contention, ER_BURST=4
  - Stimulus: both reqs held 20 cycles.
  - Required: grants ER,ER,ER,ER,CPU repeating; never a simultaneous ack; first grant ER.
- Mid-read reset
  - Stimulus: CPU read accepted, then rst asserted the next cycle.
  - Required: no cpu_rvalid afterwards; cpu_dout 0; the next contention grants ER first.
- Stats (VRAM_ARB_STATS_EN)
  - Stimulus: contention 10 cycles with ER_BURST=4.
  - Required: cpu_wait_cnt = 8; pulse stats_clr and it reads 0 on the next cycle.
